// File: rtl/uart_irq_arbiter.sv
// Round-robin arbiter folding per-UART interrupt edges onto one CPU line (UART_IRQ_ARBITER_FIXED_PRIORITY_EN selects lowest-index-first).
// Latency: rise sampled at edge k -> irq_out/irq_id registered at edge k+1; one deasserted cycle between grants.
// Backpressure: grant held until irq_ack, mask withdrawal or ACK_TIMEOUT; further rises stay pending meanwhile.
module uart_irq_arbiter #(
    parameter int DEVICE_COUNT  = 4,
    parameter int ACK_TIMEOUT   = 1024,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DEVICE_COUNT-1:0] uart_irq,
    input  logic [DEVICE_COUNT-1:0] irq_mask,
    input  logic                    irq_ack,
    output logic                    irq_out,
    output logic [7:0]              irq_id,
    output logic                    irq_timeout
);

    typedef enum logic {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST =
        (ACK_TIMEOUT == 0) ? '0 : COUNTER_WIDTH'(ACK_TIMEOUT - 1);

    state_t                   state, state_nxt;
    logic [DEVICE_COUNT-1:0]  pending, pending_nxt;
    logic [DEVICE_COUNT-1:0]  irq_prev, rise, eligible, clr;
    logic [4:0]               last_grant, last_grant_nxt;
    logic [4:0]               grant_idx, grant_idx_nxt;
    logic [4:0]               sel;
    logic                     found;
    logic [COUNTER_WIDTH-1:0] counter, counter_nxt;
    logic                     irq_out_nxt, irq_timeout_nxt;
    logic [7:0]               irq_id_nxt;
    logic                     timeout_hit;
    logic [31:0]              mask_ext, elig_ext;

    assign rise        = uart_irq & ~irq_prev;
    assign eligible    = pending & ~irq_mask;
    assign mask_ext    = 32'(irq_mask);
    assign elig_ext    = 32'(eligible);
    assign timeout_hit = (ACK_TIMEOUT != 0) && (counter == TIMEOUT_LAST);

`ifdef UART_IRQ_ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < DEVICE_COUNT; i++) begin
            if (!found && elig_ext[5'(i)]) begin
                found = 1'b1;
                sel   = 5'(i);
            end
        end
    end
`else
    // Search starts one past the last served source and wraps modulo DEVICE_COUNT.
    always_comb begin
        logic [5:0] cand;
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int off = 1; off <= DEVICE_COUNT; off++) begin
            cand = {1'b0, last_grant} + 6'(off);
            if (cand >= 6'(DEVICE_COUNT)) begin
                cand = cand - 6'(DEVICE_COUNT);
            end
            if (!found && elig_ext[cand[4:0]]) begin
                found = 1'b1;
                sel   = cand[4:0];
            end
        end
    end
`endif

    always_comb begin
        state_nxt       = state;
        clr             = '0;
        last_grant_nxt  = last_grant;
        grant_idx_nxt   = grant_idx;
        counter_nxt     = counter;
        irq_out_nxt     = irq_out;
        irq_id_nxt      = irq_id;
        irq_timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                counter_nxt = '0;
                if (found) begin
                    irq_out_nxt   = 1'b1;
                    irq_id_nxt    = 8'(sel) + 8'd1;
                    grant_idx_nxt = sel;
                    state_nxt     = ASSERT;
                end else begin
                    irq_out_nxt = 1'b0;
                    irq_id_nxt  = 8'd0;
                end
            end
            ASSERT: begin
                counter_nxt = counter + COUNTER_WIDTH'(1);
                if (irq_ack) begin
                    for (int i = 0; i < DEVICE_COUNT; i++) begin
                        clr[i] = (grant_idx == 5'(i));
                    end
                    last_grant_nxt = grant_idx;
                    irq_out_nxt    = 1'b0;
                    irq_id_nxt     = 8'd0;
                    state_nxt      = IDLE;
                end else if (mask_ext[grant_idx]) begin
                    irq_out_nxt = 1'b0;
                    irq_id_nxt  = 8'd0;
                    state_nxt   = IDLE;
                end else if (timeout_hit) begin
                    last_grant_nxt  = grant_idx;
                    irq_timeout_nxt = 1'b1;
                    irq_out_nxt     = 1'b0;
                    irq_id_nxt      = 8'd0;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A rise landing on the ack edge must survive the clear.
        pending_nxt = (pending & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            irq_prev    <= '0;
            last_grant  <= 5'(DEVICE_COUNT - 1);
            grant_idx   <= '0;
            counter     <= '0;
            irq_out     <= 1'b0;
            irq_id      <= 8'd0;
            irq_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            irq_prev    <= uart_irq;
            last_grant  <= last_grant_nxt;
            grant_idx   <= grant_idx_nxt;
            counter     <= counter_nxt;
            irq_out     <= irq_out_nxt;
            irq_id      <= irq_id_nxt;
            irq_timeout <= irq_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_uart_irq_arbiter.sv
// Bench for uart_irq_arbiter: directed scenarios then random traffic, each cycle's expected outputs
// come from a grant-level model and are queued for a monitor that checks after every clock edge.
module tb_uart_irq_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] uart_irq;
    logic [N-1:0] irq_mask;
    logic         irq_ack;
    logic         irq_out;
    logic [7:0]   irq_id;
    logic         irq_timeout;

    always #5 clk = ~clk;

    uart_irq_arbiter #(
        .DEVICE_COUNT (N),
        .ACK_TIMEOUT  (TO),
        .COUNTER_WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_irq   (uart_irq),
        .irq_mask   (irq_mask),
        .irq_ack    (irq_ack),
        .irq_out    (irq_out),
        .irq_id     (irq_id),
        .irq_timeout(irq_timeout)
    );

    typedef struct packed {
        logic       out;
        logic [7:0] id;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model: which sources are owed service, who holds the line and for how long.
    bit [N-1:0] m_pend;
    bit [N-1:0] m_prev;
    int         m_last;
    bit         m_busy;
    int         m_g;
    int         m_age;

    function automatic int pick(input bit [N-1:0] elig, input int last);
`ifdef UART_IRQ_ARBITER_FIXED_PRIORITY_EN
        for (int k = 0; k < N; k++) if (elig[k]) return k;
`else
        for (int k = 1; k <= N; k++) if (elig[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit [N-1:0] irq, input bit [N-1:0] mask,
                              input bit ack);
        exp_t       e;
        bit [N-1:0] rise;
        bit         fired;
        e     = '0;
        fired = 1'b0;
        if (r) begin
            m_pend = '0;
            m_prev = '0;
            m_last = N - 1;
            m_busy = 1'b0;
            m_age  = 0;
        end else begin
            rise = irq & ~m_prev;
            if (m_busy) begin
                m_age++;
                if (ack) begin
                    m_pend[m_g] = 1'b0;
                    m_last      = m_g;
                    m_busy      = 1'b0;
                end else if (mask[m_g]) begin
                    m_busy = 1'b0;
                end else if (TO != 0 && m_age == TO) begin
                    m_last = m_g;
                    m_busy = 1'b0;
                    fired  = 1'b1;
                end
            end else if ((m_pend & ~mask) != '0) begin
                m_g    = pick(m_pend & ~mask, m_last);
                m_busy = 1'b1;
                m_age  = 0;
            end
            m_pend = m_pend | rise;
            m_prev = irq;
            e.out  = m_busy;
            e.id   = m_busy ? 8'(m_g + 1) : 8'd0;
            e.to   = fired;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit [N-1:0] irq, input bit [N-1:0] mask,
                         input bit ack);
        @(negedge clk);
        rst      = r;
        uart_irq = irq;
        irq_mask = mask;
        irq_ack  = ack;
        model_step(r, irq, mask, ack);
    endtask

    task automatic run(input int n, input bit [N-1:0] irq, input bit [N-1:0] mask,
                       input bit auto_ack);
        repeat (n) drive(1'b0, irq, mask, auto_ack && m_busy);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                tests++;
                if (irq_out !== mon_e.out || irq_id !== mon_e.id || irq_timeout !== mon_e.to) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d: got out=%0b id=%0d to=%0b, want out=%0b id=%0d to=%0b",
                             cyc, irq_out, irq_id, irq_timeout, mon_e.out, mon_e.id, mon_e.to);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d checks pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bit [N-1:0] cur_irq;
        bit [N-1:0] cur_mask;
        bit         r;
        bit         ack;
        int         ack_pct;
        rst      = 1'b1;
        uart_irq = '0;
        irq_mask = '0;
        irq_ack  = 1'b0;
        cur_irq  = '0;
        cur_mask = '0;

        drive(1'b1, '0, '0, 1'b0);
        drive(1'b1, '0, '0, 1'b0);
        // Single pulse on source 2, acked.
        drive(1'b0, 4'b0100, '0, 1'b0);
        run(4, '0, '0, 1'b1);
        // Three simultaneous rises, then a pair that exercises the wrap.
        drive(1'b0, 4'b1011, '0, 1'b0);
        run(10, '0, '0, 1'b1);
        drive(1'b0, 4'b1001, '0, 1'b0);
        run(8, '0, '0, 1'b1);
        // Masked rise is latched but held off until the mask drops.
        drive(1'b0, 4'b0010, 4'b0010, 1'b0);
        run(3, '0, 4'b0010, 1'b0);
        run(5, '0, '0, 1'b1);
        // Unacknowledged grant times out and is regranted.
        drive(1'b0, 4'b0001, '0, 1'b0);
        run(20, '0, '0, 1'b0);
        run(3, '0, '0, 1'b1);
        // Ack coinciding with a fresh rise on the granted source.
        drive(1'b0, 4'b0001, '0, 1'b0);
        run(2, '0, '0, 1'b0);
        drive(1'b0, 4'b0001, '0, 1'b1);
        run(5, '0, '0, 1'b1);
        // Fixed-priority scenario (also valid round-robin traffic).
        drive(1'b0, 4'b1100, '0, 1'b0);
        run(6, '0, '0, 1'b1);
        drive(1'b0, 4'b1000, '0, 1'b0);
        run(2, '0, '0, 1'b0);
        drive(1'b0, 4'b0001, '0, 1'b0);
        run(6, '0, '0, 1'b1);
        // Reset while a grant is held drops everything.
        drive(1'b0, 4'b0100, '0, 1'b0);
        run(2, '0, '0, 1'b0);
        drive(1'b1, '0, '0, 1'b0);
        run(4, '0, '0, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            case ((c / 500) % 3)
                0:       ack_pct = 40;
                1:       ack_pct = 10;
                default: ack_pct = 0;
            endcase
            r       = ($urandom_range(0, 299) == 0);
            cur_irq = cur_irq ^ (N'($urandom) & N'($urandom));
            if ($urandom_range(0, 19) == 0) cur_mask = N'($urandom) & N'($urandom);
            if (m_busy) ack = ($urandom_range(0, 99) < ack_pct);
            else        ack = ($urandom_range(0, 9) == 0);
            drive(r, cur_irq, cur_mask, ack);
        end

        @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
